// File: rtl/dmem_nic_access_ctrl_pkg.sv
// Shared types and constants for the stage-3 DMEM/NIC access sequencer.
package dmem_nic_access_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDmemAcc,
        StDmemRsp,
        StNicAcc,
        StAck
    } state_e;

    // NIC register window offsets
    localparam logic [1:0] NicChInBuf   = 2'd0;
    localparam logic [1:0] NicChInStat  = 2'd1;
    localparam logic [1:0] NicChOutBuf  = 2'd2;
    localparam logic [1:0] NicChOutStat = 2'd3;

    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_nic_access_ctrl_access_timer.sv
// Saturating event counter: clear, step, and flag once Limit steps have been counted.
module dmem_nic_access_ctrl_access_timer
    import dmem_nic_access_ctrl_pkg::*;
#(
    parameter int unsigned Limit = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic expired
);

    localparam int unsigned W = timer_width(Limit);
    localparam logic [W-1:0] LimitVal = W'(Limit);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (step && (cnt_q != LimitVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LimitVal);

endmodule

// File: rtl/dmem_nic_access_ctrl.sv
// Stage-3 memory-access sequencer: serialises CPU loads/stores onto DMEM or the NIC window,
// sharing DMEM with an external loader port.
module dmem_nic_access_ctrl
    import dmem_nic_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned DMEM_ADDRESS_LENGTH = 16,
    parameter int unsigned NIC_ADDR_WIDTH      = 2,
    parameter int unsigned NIC_TIMEOUT         = 15,
    parameter int unsigned EXT_MAX_WAIT        = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cpu_req,
    input  logic                           cpu_wr,
    input  logic                           cpu_nic_sel,
    input  logic [DMEM_ADDRESS_LENGTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]          cpu_wdata,
    output logic                           cpu_stall,
    output logic                           cpu_ack,
    output logic [DATA_WIDTH-1:0]          cpu_rdata,
    input  logic                           ext_req,
    input  logic                           ext_wr,
    input  logic [DMEM_ADDRESS_LENGTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]          ext_wdata,
    output logic                           ext_gnt,
    output logic                           ext_rvalid,
    output logic [DATA_WIDTH-1:0]          ext_rdata,
    output logic                           dmem_en,
    output logic                           dmem_wr_en,
    output logic [DMEM_ADDRESS_LENGTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]          dmem_din,
    input  logic [DATA_WIDTH-1:0]          dmem_dout,
    output logic                           nic_en,
    output logic                           nic_wr_en,
    output logic [NIC_ADDR_WIDTH-1:0]      nic_addr,
    output logic [DATA_WIDTH-1:0]          nic_din,
    input  logic [DATA_WIDTH-1:0]          nic_dout,
    input  logic                           nic_ready,
    output logic                           err_timeout
);

    state_e                         state_q, state_d;
    logic                           ext_q, ext_d;
    logic                           wr_q, wr_d;
    logic [DMEM_ADDRESS_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic                           err_q, err_d;
    logic                           grant_ext, grant_cpu;
    logic                           wait_expired, tmo_expired;
    logic                           in_dmem_acc, in_nic_acc, in_ack;

    // Ext starvation guard: counts arbitrations the loader loses to the CPU.
    dmem_nic_access_ctrl_access_timer #(
        .Limit(EXT_MAX_WAIT)
    ) u_ext_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_ext),
        .step   (grant_cpu & ext_req),
        .expired(wait_expired)
    );

    // Counts NIC cycles without nic_ready; expiry on the NIC_TIMEOUT-th cycle.
    dmem_nic_access_ctrl_access_timer #(
        .Limit(NIC_TIMEOUT - 1)
    ) u_nic_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == StIdle),
        .step   (in_nic_acc & ~nic_ready),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        ext_d     = ext_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        err_d     = err_q;
        grant_ext = 1'b0;
        grant_cpu = 1'b0;
        unique case (state_q)
            StIdle: begin
                data_d = '0;
                if (ext_req && (!cpu_req || wait_expired)) begin
                    grant_ext = 1'b1;
                    state_d   = StDmemAcc;
                    ext_d     = 1'b1;
                    wr_d      = ext_wr;
                    addr_d    = ext_addr;
                    wdata_d   = ext_wdata;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_d   = cpu_nic_sel ? StNicAcc : StDmemAcc;
                    ext_d     = 1'b0;
                    wr_d      = cpu_wr;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wdata;
                end
            end
            StDmemAcc: state_d = wr_q ? StAck : StDmemRsp;
            StDmemRsp: begin
                data_d  = dmem_dout;
                state_d = StAck;
            end
            StNicAcc: begin
                if (nic_ready) begin
                    if (!wr_q) begin
                        data_d = nic_dout;
                    end
                    state_d = StAck;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ext_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign in_dmem_acc = (state_q == StDmemAcc);
    assign in_nic_acc  = (state_q == StNicAcc);
    assign in_ack      = (state_q == StAck);

    assign dmem_en     = in_dmem_acc;
    assign dmem_wr_en  = in_dmem_acc & wr_q;
    assign dmem_addr   = in_dmem_acc ? addr_q : '0;
    assign dmem_din    = (in_dmem_acc & wr_q) ? wdata_q : '0;

    assign nic_en      = in_nic_acc;
    assign nic_wr_en   = in_nic_acc & wr_q;
    assign nic_addr    = in_nic_acc ? addr_q[NIC_ADDR_WIDTH-1:0] : '0;
    assign nic_din     = (in_nic_acc & wr_q) ? wdata_q : '0;

    assign cpu_ack     = in_ack & ~ext_q;
    assign cpu_rdata   = cpu_ack ? data_q : '0;
    assign cpu_stall   = cpu_req & ~cpu_ack;
    assign ext_gnt     = in_dmem_acc & ext_q;
    assign ext_rvalid  = in_ack & ext_q & ~wr_q;
    assign ext_rdata   = ext_rvalid ? data_q : '0;
    assign err_timeout = err_q;

endmodule
